// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store engine with dmem request/grant/response handshake
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] aluResult,
    input  logic [31:0] aluOperand2,
    input  logic [4:0]  rd,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memSize,
    input  logic        memUnsigned,
    input  logic        memToReg,
    input  logic        regWrite,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wbDataOut,
    output logic [4:0]  rdOut,
    output logic        regWriteOut,
    output logic        misalignedOut
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} stateT;

    stateT       state;
    logic        access;
    logic        aligned;
    logic [31:0] storeData;
    logic [3:0]  storeBe;
    logic [31:0] loadLane;
    logic [31:0] loadData;

    logic [1:0]  sizeQ;
    logic        unsignedQ;
    logic        memToRegQ;
    logic        regWriteQ;
    logic [4:0]  rdQ;
    logic [31:0] aluQ;
    logic [31:0] loadQ;

    always_comb begin
        access = memRead | memWrite;
        case (memSize)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~aluResult[0];
            default: aligned = (aluResult[1:0] == 2'b00);
        endcase

        case (memSize)
            2'b00: begin
                storeData = {4{aluOperand2[7:0]}};
                storeBe   = 4'b0001 << aluResult[1:0];
            end
            2'b01: begin
                storeData = {2{aluOperand2[15:0]}};
                storeBe   = 4'b0011 << {aluResult[1], 1'b0};
            end
            default: begin
                storeData = aluOperand2;
                storeBe   = 4'b1111;
            end
        endcase

        // Byte offset comes from the latched address; dmem_addr has its low bits cleared.
        loadLane = dmem_rdata >> {aluQ[1:0], 3'b000};
        case (sizeQ)
            2'b00:   loadData = unsignedQ ? {24'b0, loadLane[7:0]}
                                          : {{24{loadLane[7]}}, loadLane[7:0]};
            2'b01:   loadData = unsignedQ ? {16'b0, loadLane[15:0]}
                                          : {{16{loadLane[15]}}, loadLane[15:0]};
            default: loadData = dmem_rdata;
        endcase

        stall = resetn & (((state == IDLE) & access & aligned) | (state == REQ) | (state == RESP));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'b0;
            dmem_wdata    <= 32'b0;
            dmem_be       <= 4'b0;
            wbDataOut     <= 32'b0;
            rdOut         <= 5'b0;
            regWriteOut   <= 1'b0;
            misalignedOut <= 1'b0;
            sizeQ         <= 2'b0;
            unsignedQ     <= 1'b0;
            memToRegQ     <= 1'b0;
            regWriteQ     <= 1'b0;
            rdQ           <= 5'b0;
            aluQ          <= 32'b0;
            loadQ         <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!access) begin
                        wbDataOut     <= aluResult;
                        rdOut         <= rd;
                        regWriteOut   <= regWrite;
                        misalignedOut <= 1'b0;
                    end else if (!aligned) begin
                        wbDataOut     <= aluResult;
                        rdOut         <= rd;
                        regWriteOut   <= 1'b0;
                        misalignedOut <= 1'b1;
                    end else begin
                        dmem_req      <= 1'b1;
                        dmem_we       <= memWrite;
                        dmem_addr     <= {aluResult[31:2], 2'b00};
                        dmem_wdata    <= storeData;
                        dmem_be       <= storeBe;
                        sizeQ         <= memSize;
                        unsignedQ     <= memUnsigned;
                        memToRegQ     <= memToReg;
                        regWriteQ     <= regWrite;
                        rdQ           <= rd;
                        aluQ          <= aluResult;
                        regWriteOut   <= 1'b0;
                        misalignedOut <= 1'b0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    regWriteOut   <= 1'b0;
                    misalignedOut <= 1'b0;
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        state    <= dmem_we ? DONE : RESP;
                    end
                end
                RESP: begin
                    regWriteOut   <= 1'b0;
                    misalignedOut <= 1'b0;
                    if (dmem_rvalid) begin
                        loadQ <= loadData;
                        state <= DONE;
                    end
                end
                DONE: begin
                    wbDataOut     <= (memToRegQ && !dmem_we) ? loadQ : aluQ;
                    rdOut         <= rdQ;
                    regWriteOut   <= regWriteQ;
                    misalignedOut <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store engine sitting between the EX/MEM pipeline register and the data-memory port. Consumes the EX/MEM outputs (address, store operand, rd, memory/writeback controls), runs a request/grant/response handshake with data memory, formats store byte lanes and load results, and stalls the pipeline until the access completes. Its registered outputs form the MEM/WB stage register.

## Interface
- No parameters.
- clk  in  1  clock
- resetn  in  1  reset: synchronous, active-low
- aluResult  in  32  effective address, or ALU result for non-memory ops
- aluOperand2  in  32  store data
- rd  in  5  destination register
- memRead, memWrite  in  1  access type
- memSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- memUnsigned  in  1  zero-extend loads when 1
- memToReg, regWrite  in  1  writeback controls
- stall  out  1  combinational; upstream stages hold while 1
- dmem_req  out  1  registered request
- dmem_we  out  1  write request
- dmem_addr  out  32  word-aligned address {aluResult[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- wbDataOut  out  32  load result when memToReg=1, else aluResult
- rdOut  out  5  destination register
- regWriteOut  out  1  writeback enable
- misalignedOut  out  1  one-cycle flag for a misaligned access

## Operation
- access = memRead | memWrite. If both are 1, the op is a write.
- Aligned when: byte always; half needs addr[0]=0; word needs addr[1:0]=00.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - No access: each edge loads wbDataOut=aluResult, rdOut=rd, regWriteOut=regWrite, misalignedOut=0.
  - Misaligned access: no request; loads regWriteOut=0, misalignedOut=1, rdOut=rd, wbDataOut=aluResult.
  - Aligned access: latches address, wdata, be, we, size, unsigned, rd, and regWrite. Goes to REQ with dmem_req=1.
- REQ: holds dmem_* stable. On dmem_gnt, a write goes to DONE and a read goes to RESP. dmem_req drops on the same edge.
- RESP: on dmem_rvalid, captures the formatted load data and goes to DONE.
- DONE: loads the MEM/WB outputs (regWriteOut = latched regWrite; wbDataOut = load data for reads). Returns to IDLE.
- Store formatting:
  - byte: wdata={4{op2[7:0]}}, be=0001<<addr[1:0]
  - half: wdata={2{op2[15:0]}}, be=0011<<{addr[1],1'b0}
  - word: wdata=op2, be=1111
- Load formatting:
  - Lane = rdata >> (8*addr[1:0]).
  - Byte and half are sign-extended, or zero-extended when memUnsigned=1. Word is unchanged.
- stall = (IDLE & access & aligned) | REQ | RESP. stall is 0 in DONE.
- Every edge taken while stall=1 loads regWriteOut=0 and misalignedOut=0 (bubble).
- dmem_rvalid is ignored outside RESP. dmem_gnt is ignored outside REQ.

## Timing
- Reset values: state IDLE; all outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wbDataOut, rdOut, regWriteOut, misalignedOut). stall=0 during reset.
- resetn low mid-access: returns to IDLE next edge and drops dmem_req. A late rvalid is discarded.
- Non-memory and misaligned ops: 1-cycle latency, identical to a plain pipeline register.
- Write, with gnt on the first REQ cycle: IDLE → REQ → DONE, 3 cycles, stall high for 2.
- Read, with gnt and then rvalid on the next cycle: IDLE → REQ → RESP → DONE, 4 cycles, stall high for 3.
- Every extra cycle of gnt or rvalid latency adds one stall cycle.
- gnt and rvalid in the same REQ cycle: rvalid is ignored, so rdata must come in RESP.
- In DONE the same instruction is still on the inputs; it is not relaunched.

## Test plan
- ALU op: aluResult=0x1234, rd=5, regWrite=1, no access → next edge wbDataOut=0x1234, rdOut=5, regWriteOut=1, stall never high.
- Store byte: addr=0x1003, op2=0xAB, gnt immediate → dmem_addr=0x1000, be=1000, wdata=0xABABABAB, we=1. stall high for 2 cycles; regWriteOut stays 0.
- Load half, signed: addr=0x2002, rdata=0x8001xxxx, gnt immediate, rvalid after 2 cycles → wbDataOut=0xFFFF8001, regWriteOut=1 at the DONE edge, stall high for 4 cycles. With memUnsigned=1 the result is 0x00008001.
- Misaligned word: addr=0x3001, memRead=1 → no dmem_req; next edge misalignedOut=1, regWriteOut=0.
- Grant backpressure: dmem_gnt low for 3 cycles → dmem_req, addr, be, and wdata stay stable the whole time; completes after gnt.
- Reset in RESP: resetn low for 1 cycle → state IDLE, dmem_req=0, all outputs 0. A subsequent rvalid=1 is ignored and regWriteOut stays 0.
